// File: rtl/n64_poll_scheduler.sv
// Joybus host sequencer: detects a controller with INFO, then polls it every POLL_PERIOD ticks
// and latches buttons/stick from each good response.
module n64_poll_scheduler #(
  parameter int unsigned POLL_PERIOD  = 33333,
  parameter int unsigned RESP_TIMEOUT = 200,
  parameter int unsigned MAX_MISSES   = 3
) (
  input  logic        sample_clk,
  input  logic        reset,
  input  logic        data_rx,
  output logic        data_oe,
  output logic [15:0] button_state,
  output logic [7:0]  stick_x,
  output logic [7:0]  stick_y,
  output logic        state_valid,
  output logic        poll_strobe,
  output logic        controller_present,
  output logic        busy
);

  localparam int unsigned PW = $clog2(POLL_PERIOD);
  localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned MW = $clog2(MAX_MISSES + 1);
  localparam logic [PW-1:0] PeriodLast  = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(RESP_TIMEOUT - 1);
  localparam logic [MW-1:0] MissLast    = MW'(MAX_MISSES - 1);

  typedef enum logic [2:0] {
    StIdle, StSendCmd, StSendStop, StWaitResp, StRecvBits, StRecvStop, StDone, StFail
  } state_e;

  logic       rx_meta, rx_sync, rx_prev;
  logic [2:0] oe_hist;
  logic       rx_fall, rx_rise;

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      oe_hist <= '0;
    end else begin
      rx_meta <= data_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      oe_hist <= {oe_hist[1:0], data_oe};
    end
  end

  // Falls that trail our own drive through the synchroniser are not controller edges.
  assign rx_fall = rx_prev & ~rx_sync & ~(|oe_hist);
  assign rx_rise = ~rx_prev & rx_sync;

  state_e        state_q;
  logic [PW-1:0] period_q;
  logic          running_q;
  logic          start_pending_q;
  logic [TW-1:0] timeout_q;
  logic [MW-1:0] miss_q;
  logic [2:0]    tick_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    cmd_q;
  logic [5:0]    rx_cnt_q;
  logic [2:0]    samp_q;
  logic          samp_pend_q;
  logic          stop_seen_q;
  logic [31:0]   shift_q;
  logic          start;
  logic          last_rx_bit;

  assign start       = start_pending_q | (running_q && (period_q == PeriodLast));
  assign last_rx_bit = rx_cnt_q == (cmd_q[0] ? 6'd31 : 6'd23);

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      state_q            <= StIdle;
      period_q           <= '0;
      running_q          <= 1'b0;
      start_pending_q    <= 1'b1;
      timeout_q          <= '0;
      miss_q             <= '0;
      tick_q             <= '0;
      bit_idx_q          <= '0;
      cmd_q              <= '0;
      rx_cnt_q           <= '0;
      samp_q             <= '0;
      samp_pend_q        <= 1'b0;
      stop_seen_q        <= 1'b0;
      shift_q            <= '0;
      data_oe            <= 1'b0;
      button_state       <= '0;
      stick_x            <= '0;
      stick_y            <= '0;
      state_valid        <= 1'b0;
      poll_strobe        <= 1'b0;
      controller_present <= 1'b0;
      busy               <= 1'b0;
    end else begin
      if (running_q) begin
        period_q <= (period_q == PeriodLast) ? '0 : period_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            start_pending_q <= 1'b0;
            running_q       <= 1'b1;
            period_q        <= '0;
            state_q         <= StSendCmd;
            busy            <= 1'b1;
            data_oe         <= 1'b1;
            tick_q          <= '0;
            bit_idx_q       <= 3'd7;
            cmd_q           <= controller_present ? 8'h01 : 8'h00;
            shift_q         <= '0;
          end
        end

        StSendCmd: begin
          if (tick_q == 3'd7) begin
            tick_q  <= '0;
            data_oe <= 1'b1;
            if (bit_idx_q == 3'd0) begin
              state_q <= StSendStop;
            end else begin
              bit_idx_q <= bit_idx_q - 3'd1;
            end
          end else begin
            tick_q  <= tick_q + 3'd1;
            data_oe <= (tick_q + 3'd1) < (cmd_q[bit_idx_q] ? 3'd2 : 3'd6);
          end
        end

        StSendStop: begin
          if (tick_q == 3'd1) begin
            data_oe   <= 1'b0;
            timeout_q <= '0;
            state_q   <= StWaitResp;
          end else begin
            tick_q <= tick_q + 3'd1;
          end
        end

        StWaitResp: begin
          if (rx_fall) begin
            timeout_q   <= '0;
            samp_pend_q <= 1'b1;
            samp_q      <= 3'd3;
            rx_cnt_q    <= '0;
            state_q     <= StRecvBits;
          end else if (timeout_q == TimeoutLast) begin
            state_q <= StFail;
          end else begin
            timeout_q <= timeout_q + 1'b1;
          end
        end

        StRecvBits: begin
          if (samp_pend_q && (samp_q == 3'd0)) begin
            samp_pend_q <= 1'b0;
            shift_q     <= {shift_q[30:0], rx_sync};
            rx_cnt_q    <= rx_cnt_q + 6'd1;
            if (last_rx_bit) begin
              stop_seen_q <= 1'b0;
              state_q     <= StRecvStop;
            end
          end else if (samp_pend_q) begin
            samp_q <= samp_q - 3'd1;
          end
          if (rx_fall) begin
            timeout_q   <= '0;
            samp_pend_q <= 1'b1;
            samp_q      <= 3'd3;
          end else if (timeout_q == TimeoutLast) begin
            state_q <= StFail;
          end else begin
            timeout_q <= timeout_q + 1'b1;
          end
        end

        StRecvStop: begin
          if (rx_fall) begin
            timeout_q   <= '0;
            stop_seen_q <= 1'b1;
          end else if (stop_seen_q && rx_rise) begin
            if (cmd_q[0]) begin
              state_q      <= StDone;
              button_state <= shift_q[31:16];
              stick_x      <= shift_q[15:8];
              stick_y      <= shift_q[7:0];
              poll_strobe  <= 1'b1;
              state_valid  <= 1'b1;
              miss_q       <= '0;
            end else if (shift_q[23:8] == 16'h0500) begin
              state_q            <= StDone;
              controller_present <= 1'b1;
              state_valid        <= 1'b0;
              miss_q             <= '0;
            end else begin
              state_q <= StFail;
            end
          end else if (timeout_q == TimeoutLast) begin
            state_q <= StFail;
          end else begin
            timeout_q <= timeout_q + 1'b1;
          end
        end

        StDone: begin
          poll_strobe <= 1'b0;
          busy        <= 1'b0;
          state_q     <= StIdle;
        end

        StFail: begin
          busy    <= 1'b0;
          state_q <= StIdle;
          // A failed INFO just retries; only failed POLLs count towards dropping the controller.
          if (cmd_q[0]) begin
            if (miss_q == MissLast) begin
              miss_q             <= '0;
              controller_present <= 1'b0;
              state_valid        <= 1'b0;
              button_state       <= '0;
              stick_x            <= '0;
              stick_y            <= '0;
            end else begin
              miss_q <= miss_q + 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
